// File: rtl/pixel_xform_if.sv
// Register-port and memory-port Avalon-MM signals of the pixel transform sequencer.
// The slave modport is the sequencer's own view; the master modport is the CPU/memory side.
interface pixel_xform_if #(
  parameter int ADDR_W = 32
);
  logic [2:0]        slave_address;
  logic              slave_read;
  logic              slave_write;
  logic [31:0]       slave_writedata;
  logic [31:0]       slave_readdata;
  logic [ADDR_W-1:0] master_address;
  logic              master_read;
  logic              master_write;
  logic [31:0]       master_writedata;
  logic [31:0]       master_readdata;
  logic              master_readdatavalid;
  logic              master_waitrequest;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata,
    output slave_readdata,
    output master_address, master_read, master_write, master_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest
  );

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata,
    input  slave_readdata,
    input  master_address, master_read, master_write, master_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest
  );
endinterface

// File: rtl/pixel_xform_ctrl.sv
// Copies COUNT 32-bit pixels from SRC to DST, one read then one write per pixel,
// applying a per-byte transform selected by OP between the read and the write.
module pixel_xform_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  pixel_xform_if.slave bus,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, NEXT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, rem_q, rem_d;
  logic [1:0]        mode_q, mode_d, wmode_q, wmode_d;
  logic [7:0]        k_q, k_d, wk_q, wk_d;
  logic [31:0]       pix_q, pix_d, rdata_q, rdata_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              cfg_we, start;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [31:0] xform(input logic [31:0] w, input logic [1:0] mode,
                                        input logic [7:0] k);
    logic [31:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      case (mode)
        2'd0:    r[8*i +: 8] = b;
        2'd1:    r[8*i +: 8] = ~b;
        2'd2:    r[8*i +: 8] = sat_add8(b, k);
        default: r[8*i +: 8] = b >> 1;
      endcase
    end
    return r;
  endfunction

  // Configuration is frozen while a job runs; a CTRL write only starts from IDLE.
  assign cfg_we = bus.slave_write && !busy_q;
  assign start  = bus.slave_write && (bus.slave_address == 3'd0) && (state_q == IDLE);

  assign busy               = busy_q;
  assign bus.slave_readdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      mode_q    <= '0;
      wmode_q   <= '0;
      k_q       <= '0;
      wk_q      <= '0;
      pix_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      wmode_q   <= wmode_d;
      k_q       <= k_d;
      wk_q      <= wk_d;
      pix_q     <= pix_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    wmode_d   = wmode_q;
    k_d       = k_q;
    wk_d      = wk_q;
    pix_d     = pix_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = done_q;

    bus.master_read      = 1'b0;
    bus.master_write     = 1'b0;
    bus.master_address   = '0;
    bus.master_writedata = '0;

    if (cfg_we) begin
      case (bus.slave_address)
        3'd1: src_d   = ADDR_W'(bus.slave_writedata);
        3'd2: dst_d   = ADDR_W'(bus.slave_writedata);
        3'd3: count_d = CNT_W'(bus.slave_writedata);
        3'd4: begin
          mode_d = bus.slave_writedata[1:0];
          k_d    = bus.slave_writedata[15:8];
        end
        default: ;
      endcase
    end

    if (bus.slave_read) begin
      case (bus.slave_address)
        3'd0:    rdata_d = {30'b0, done_q, busy_q};
        3'd1:    rdata_d = 32'(src_q);
        3'd2:    rdata_d = 32'(dst_q);
        3'd3:    rdata_d = 32'(count_q);
        3'd4:    rdata_d = {16'b0, k_q, 6'b0, mode_q};
        default: rdata_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d = src_q;
          dst_ptr_d = dst_q;
          rem_d     = count_q;
          wmode_d   = mode_q;
          wk_d      = k_q;
          done_d    = 1'b0;
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        bus.master_read    = 1'b1;
        bus.master_address = src_ptr_q;
        if (!bus.master_waitrequest) begin
          // Zero-latency memories return data in the accepting cycle.
          if (bus.master_readdatavalid) begin
            pix_d   = bus.master_readdata;
            state_d = WR_REQ;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (bus.master_readdatavalid) begin
          pix_d   = bus.master_readdata;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        bus.master_write     = 1'b1;
        bus.master_address   = dst_ptr_q;
        bus.master_writedata = xform(pix_q, wmode_q, wk_q);
        if (!bus.master_waitrequest) state_d = NEXT;
      end
      NEXT: begin
        src_ptr_d = src_ptr_q + ADDR_W'(4);
        dst_ptr_d = dst_ptr_q + ADDR_W'(4);
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_xform_ctrl.sv
// Directed bench for pixel_xform_ctrl: register port driven as the CPU would,
// memory port answered by a small waitstate-programmable memory model.
module tb_pixel_xform_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  pixel_xform_if #(.ADDR_W(32)) bus();

  pixel_xform_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [logic [31:0]];
  wr_t         wlog [$];
  int          n_rd = 0, n_wr = 0, n_req = 0;
  int          rd_ws = 0, wr_ws = 0, rd_cnt = 0, wr_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_pend_a = '0, cap_a = '0, cap_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: read latency 1, programmable waitstates per request.
  initial begin
    bus.master_readdata      = '0;
    bus.master_readdatavalid = 1'b0;
    bus.master_waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_pend = 1'b0;
        rd_cnt  = 0;
        wr_cnt  = 0;
        bus.master_readdatavalid = 1'b0;
        bus.master_waitrequest   = 1'b0;
      end else begin
        bus.master_readdatavalid = rd_pend;
        bus.master_readdata      = rd_pend ? mem[rd_pend_a] : 32'h0;
        rd_pend = 1'b0;
        if (bus.master_read || bus.master_write) n_req++;
        if (bus.master_read && bus.master_write)
          chk("rd_wr_excl", {30'b0, bus.master_read, bus.master_write}, 32'h1);
        if (rd_cnt != 0) chk("rd_held", {31'b0, bus.master_read}, 32'h1);
        if (wr_cnt != 0) chk("wr_held", {31'b0, bus.master_write}, 32'h1);
        if (bus.master_read) begin
          if (rd_cnt == 0) cap_a = bus.master_address;
          else chk("rd_addr_stable", bus.master_address, cap_a);
          if (rd_cnt < rd_ws) begin
            bus.master_waitrequest = 1'b1;
            rd_cnt++;
          end else begin
            bus.master_waitrequest = 1'b0;
            rd_cnt    = 0;
            rd_pend   = 1'b1;
            rd_pend_a = bus.master_address;
            n_rd++;
          end
        end else if (bus.master_write) begin
          if (wr_cnt == 0) begin
            cap_a = bus.master_address;
            cap_d = bus.master_writedata;
          end else begin
            chk("wr_addr_stable", bus.master_address, cap_a);
            chk("wr_data_stable", bus.master_writedata, cap_d);
          end
          if (wr_cnt < wr_ws) begin
            bus.master_waitrequest = 1'b1;
            wr_cnt++;
          end else begin
            bus.master_waitrequest = 1'b0;
            wr_cnt = 0;
            wlog.push_back('{a: bus.master_address, d: bus.master_writedata});
            n_wr++;
          end
        end else begin
          bus.master_waitrequest = 1'b0;
        end
      end
    end
  end

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.slave_address   = a;
    bus.slave_writedata = d;
    bus.slave_write     = 1'b1;
    @(negedge clk);
    bus.slave_write     = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.slave_address = a;
    bus.slave_read    = 1'b1;
    @(negedge clk);
    bus.slave_read    = 1'b0;
    d = bus.slave_readdata;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wlog.size()) begin
      chk($sformatf("wr%0d_addr", idx), wlog[idx].a, a);
      chk($sformatf("wr%0d_data", idx), wlog[idx].d, d);
    end else begin
      chk($sformatf("wr%0d_missing", idx), wlog.size(), idx + 1);
    end
  endtask

  task automatic run1(input string tag, input logic [31:0] op, input logic [31:0] word,
                      input logic [31:0] exp);
    int cyc;
    mem[32'h4000] = word;
    wlog.delete();
    reg_wr(3'd1, 32'h4000);
    reg_wr(3'd2, 32'h4100);
    reg_wr(3'd3, 32'd1);
    reg_wr(3'd4, op);
    reg_wr(3'd0, 32'd1);
    wait_idle(cyc);
    chk({tag, "_nwr"}, wlog.size(), 32'd1);
    chk_wr(0, 32'h4100, exp);
  endtask

  initial begin
    logic [31:0] r;
    int          cyc, base_rd, base_wr, base_req, bsy_seen;
    bus.slave_address   = '0;
    bus.slave_read      = 1'b0;
    bus.slave_write     = 1'b0;
    bus.slave_writedata = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'b0, busy}, 32'h0);
    chk("rst_mrd",   {31'b0, bus.master_read}, 32'h0);
    chk("rst_mwr",   {31'b0, bus.master_write}, 32'h0);
    chk("rst_maddr", bus.master_address, 32'h0);
    chk("rst_mwd",   bus.master_writedata, 32'h0);
    chk("rst_srd",   bus.slave_readdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), r);
      chk($sformatf("rst_reg%0d", i), r, 32'h0);
    end

    // COUNT=0 start: done without busy or bus traffic.
    base_req = n_req;
    reg_wr(3'd1, 32'h5000);
    reg_wr(3'd3, 32'd0);
    reg_wr(3'd0, 32'd1);
    bsy_seen = 0;
    repeat (6) begin
      if (busy) bsy_seen++;
      @(negedge clk);
    end
    chk("cnt0_busy", bsy_seen, 32'd0);
    chk("cnt0_req", n_req - base_req, 32'd0);
    reg_rd(3'd0, r);
    chk("cnt0_status", r, 32'h2);

    // Three-pixel invert job at full rate.
    mem[32'h1000] = 32'h00FF1234;
    mem[32'h1004] = 32'hFFFFFFFF;
    mem[32'h1008] = 32'h00000000;
    wlog.delete();
    base_rd = n_rd;
    reg_wr(3'd1, 32'h1000);
    reg_wr(3'd2, 32'h2000);
    reg_wr(3'd3, 32'd3);
    reg_wr(3'd4, 32'd1);
    reg_wr(3'd0, 32'd0);
    wait_idle(cyc);
    chk("inv_cycles", cyc, 32'd12);
    chk("inv_nrd", n_rd - base_rd, 32'd3);
    chk("inv_nwr", wlog.size(), 32'd3);
    chk_wr(0, 32'h2000, 32'hFF00EDCB);
    chk_wr(1, 32'h2004, 32'h00000000);
    chk_wr(2, 32'h2008, 32'hFFFFFFFF);
    reg_rd(3'd0, r);
    chk("inv_status", r, 32'h2);
    reg_rd(3'd3, r);
    chk("inv_count_rb", r, 32'd3);
    reg_rd(3'd4, r);
    chk("inv_op_rb", r, 32'h1);

    run1("sat", 32'h0000_1002, 32'hF80A0000, 32'hFF1A1010);
    reg_rd(3'd4, r);
    chk("sat_op_rb", r, 32'h1002);
    run1("shr", 32'h0000_0003, 32'h80FF0201, 32'h407F0100);
    run1("pass", 32'h0000_7700, 32'hA5C30F01, 32'hA5C30F01);

    // Waitstates on both request types.
    rd_ws = 5;
    wr_ws = 3;
    mem[32'h6000] = 32'h11223344;
    mem[32'h6004] = 32'h55667788;
    wlog.delete();
    base_rd = n_rd;
    base_wr = n_wr;
    reg_wr(3'd1, 32'h6000);
    reg_wr(3'd2, 32'h7000);
    reg_wr(3'd3, 32'd2);
    reg_wr(3'd4, 32'd1);
    reg_wr(3'd0, 32'd0);
    wait_idle(cyc);
    chk("ws_nrd", n_rd - base_rd, 32'd2);
    chk("ws_nwr", n_wr - base_wr, 32'd2);
    chk_wr(0, 32'h7000, 32'hEEDDCCBB);
    chk_wr(1, 32'h7004, 32'hAA998877);
    rd_ws = 0;
    wr_ws = 0;

    // Writes while busy must not disturb the running job.
    for (int i = 0; i < 4; i++) mem[32'h3000 + 32'(4*i)] = 32'(i + 1);
    wlog.delete();
    reg_wr(3'd1, 32'h3000);
    reg_wr(3'd2, 32'h3800);
    reg_wr(3'd3, 32'd4);
    reg_wr(3'd4, 32'd0);
    reg_wr(3'd0, 32'd0);
    chk("bz_window", {31'b0, busy}, 32'h1);
    reg_wr(3'd1, 32'hDEAD);
    reg_wr(3'd0, 32'd0);
    wait_idle(cyc);
    chk("bz_nwr", wlog.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk_wr(i, 32'h3800 + 32'(4*i), 32'(i + 1));
    reg_rd(3'd1, r);
    chk("bz_src_rb", r, 32'h3000);

    // Reset while the second of four writes is stalled.
    wr_ws = 10;
    wlog.delete();
    reg_wr(3'd2, 32'h3900);
    reg_wr(3'd0, 32'd0);
    cyc = 0;
    while (!(bus.master_write && wlog.size() == 1) && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("mr_reach", {31'b0, bus.master_write && wlog.size() == 1}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_mwr",   {31'b0, bus.master_write}, 32'h0);
    chk("mr_mrd",   {31'b0, bus.master_read}, 32'h0);
    chk("mr_busy",  {31'b0, busy}, 32'h0);
    chk("mr_maddr", bus.master_address, 32'h0);
    chk("mr_mwd",   bus.master_writedata, 32'h0);
    rst   = 1'b0;
    wr_ws = 0;
    base_req = n_req;
    for (int i = 0; i < 5; i++) begin
      reg_rd(3'(i), r);
      chk($sformatf("mr_reg%0d", i), r, 32'h0);
    end
    repeat (20) @(negedge clk);
    #1;
    chk("mr_req", n_req - base_req, 32'd0);
    chk("mr_nwr", wlog.size(), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_xform_ctrl.md
Name: pixel_xform_ctrl

Overview:
- Avalon-MM sequencer that moves a block of 32-bit pixels from a source buffer to a destination buffer and applies a per-pixel transform on the way.
- Software programs it through an Avalon-MM slave register port, which the Nios II drives in pixel_xform_system.
- It walks memory through an Avalon-MM master port, one read then one write per pixel. Only one transfer is outstanding at a time.

Parameters:
- ADDR_W, 32, byte-address width of the master port and of the SRC/DST registers.
- CNT_W, 16, width of the COUNT register (pixels per job).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- slave_address  in  3  word offset of the register.
- slave_read  in  1  register read strobe.
- slave_write  in  1  register write strobe.
- slave_writedata  in  32  register write data.
- slave_readdata  out  32  register read data; fixed read latency 1.
- master_address  out  ADDR_W  byte address.
- master_read  out  1  read request.
- master_write  out  1  write request.
- master_writedata  out  32  transformed pixel.
- master_readdata  in  32  source pixel.
- master_readdatavalid  in  1  read data valid.
- master_waitrequest  in  1  stall for the current request.
- busy  out  1  job in progress; mirrors STATUS[0].

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Register map (word offsets):
  - 0 CTRL/STATUS: a write of any value starts a job. A read returns {30'b0, done, busy}.
  - 1 SRC: source byte address.
  - 2 DST: destination byte address.
  - 3 COUNT: number of pixels, CNT_W bits, zero-extended on read.
  - 4 OP: [1:0] mode, [15:8] k.
  - Offsets 5-7 read as 0; writes to them are ignored.
- Slave timing: slave_readdata updates on the clock after slave_read and holds its value otherwise. There is no slave waitrequest.
- Register writes to offsets 1-4 while busy=1 are ignored. A CTRL write while busy=1 is ignored and does not restart the job.
- Transform is applied per byte b of the 32-bit word:
  - mode 0: pass-through.
  - mode 1: ~b.
  - mode 2: min(b+k, 255), saturating.
  - mode 3: b>>1.
- The transform is combinational on the latched read word. OP is sampled at start.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, NEXT.
  - IDLE: on a CTRL write, latch SRC, DST and COUNT into working counters and clear done. Go to DONE-check: if COUNT=0, set done and stay IDLE, with no bus activity and busy never asserted. Otherwise set busy and go to RD_REQ.
  - RD_REQ: master_read=1, master_address=src_ptr. Hold read and address stable while master_waitrequest=1. On waitrequest=0, go to RD_WAIT.
  - RD_WAIT: on master_readdatavalid, latch master_readdata and go to WR_REQ. Readdatavalid arriving in the same cycle as the accepted read (zero latency) is also accepted.
  - WR_REQ: master_write=1, master_address=dst_ptr, master_writedata=xform(latched). Hold all three stable while master_waitrequest=1. On waitrequest=0, go to NEXT.
  - NEXT: src_ptr+=4, dst_ptr+=4, remaining-=1. If remaining reaches 0, clear busy, set done and go to IDLE. Otherwise go to RD_REQ.
- Minimum throughput: 4 cycles per pixel with zero waitstates and readdatavalid one cycle after the accepted read.
- Pointer arithmetic is modulo 2^ADDR_W and wraps silently. Overlapping SRC/DST regions are the user's responsibility.
- master_read and master_write are never asserted in the same cycle. Both are 0 in IDLE and NEXT.
- done is sticky until the next accepted start or reset.
- Reset values: all registers 0; FSM IDLE; busy=0; done=0; master_read=0; master_write=0; master_address=0; master_writedata=0; slave_readdata=0.
- Reset mid-job abandons the job immediately with no further bus requests. A pending readdatavalid after reset is ignored.

Test Plan:
- SRC=0x1000, DST=0x2000, COUNT=3, OP mode 1, memory words 0x00FF1234, 0xFFFFFFFF, 0 -> writes at 0x2000/0x2004/0x2008 of 0xFF00EDCB, 0x00000000, 0xFFFFFFFF; then STATUS reads 0x2.
- mode 2, k=0x10, word 0xF80A0000 -> written 0xFF1A1010. mode 3, word 0x80FF0201 -> written 0x407F0100.
- master_waitrequest held high 5 cycles on the read and 3 on the write -> address, read/write and writedata stay stable throughout; exactly one read and one write are accepted per pixel.
- COUNT=0 start -> no master_read/master_write ever asserted; STATUS=0x2 on the next read.
- While busy: write SRC=0xDEAD and CTRL -> job continues with the original SRC, completes COUNT pixels, and SRC reads back the old value.
- Assert rst during WR_REQ of pixel 2 of 4 -> the next cycle has master_write=0, busy=0, STATUS=0 and all registers 0, and no further bus activity.
